// File: rtl/dual_debounce_pkg.sv
// Shared constants and types for the two-channel debouncer.
// DEBOUNCE_SIM_COUNT is the short stability window used by benches.
package dual_debounce_pkg;

    localparam int DEF_STABLE_COUNT   = 500000;
    localparam int DEF_CNT_WIDTH      = 20;
    localparam int DEBOUNCE_SIM_COUNT = 4;

    typedef enum logic {
        CH_STABLE  = 1'b0,
        CH_PENDING = 1'b1
    } chan_state_e;

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchronizer, stability counter, output flop.
// Optional rise-pulse flop when DEBOUNCE_EDGE_EN is defined.
module debounce_chan
    import dual_debounce_pkg::*;
#(
    parameter int STABLE_COUNT = DEF_STABLE_COUNT,
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
`ifdef DEBOUNCE_EDGE_EN
    output logic rise_o,
`endif
    output logic q_o
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(STABLE_COUNT - 1);

    logic                 s1_q, s2_q;
    logic                 q_q, q_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    chan_state_e          state;

    assign state = (s2_q != q_q) ? CH_PENDING : CH_STABLE;

    always_comb begin
        q_d   = q_q;
        cnt_d = '0;
        case (state)
            CH_PENDING: begin
                if (cnt_q == LAST) begin
                    q_d = s2_q;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            q_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= btn_i;
            s2_q  <= s1_q;
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end

    assign q_o = q_q;

`ifdef DEBOUNCE_EDGE_EN
    // Pulse is registered alongside q so it is high the cycle q first reads 1.
    logic rise_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rise_q <= 1'b0;
        end else begin
            rise_q <= q_d & ~q_q;
        end
    end

    assign rise_o = rise_q;
`endif

endmodule

// File: rtl/dual_debounce.sv
// Two independent debounce channels feeding the OR stage operands A and B.
// DEBOUNCE_EDGE_EN adds the A_RISE/B_RISE pulse outputs.
module dual_debounce
    import dual_debounce_pkg::*;
#(
    parameter int STABLE_COUNT = DEF_STABLE_COUNT,
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic BTN_A,
    input  logic BTN_B,
`ifdef DEBOUNCE_EDGE_EN
    output logic A_RISE,
    output logic B_RISE,
`endif
    output logic A,
    output logic B
);

    debounce_chan #(
        .STABLE_COUNT (STABLE_COUNT),
        .CNT_WIDTH    (CNT_WIDTH)
    ) u_chan_a (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .btn_i  (BTN_A),
`ifdef DEBOUNCE_EDGE_EN
        .rise_o (A_RISE),
`endif
        .q_o    (A)
    );

    debounce_chan #(
        .STABLE_COUNT (STABLE_COUNT),
        .CNT_WIDTH    (CNT_WIDTH)
    ) u_chan_b (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .btn_i  (BTN_B),
`ifdef DEBOUNCE_EDGE_EN
        .rise_o (B_RISE),
`endif
        .q_o    (B)
    );

endmodule

// File: tb/tb_dual_debounce.sv
// Scoreboard bench for dual_debounce against a windowed stability model.
module tb_dual_debounce;
    import dual_debounce_pkg::*;

    localparam int SC = DEBOUNCE_SIM_COUNT;
    localparam int CW = 3;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    logic BTN_A = 1'b0;
    logic BTN_B = 1'b0;
    logic A, B;
`ifdef DEBOUNCE_EDGE_EN
    logic A_RISE, B_RISE;
    localparam logic [3:0] MASK = 4'hF;
`else
    localparam logic [3:0] MASK = 4'hC;
`endif

    dual_debounce #(
        .STABLE_COUNT (SC),
        .CNT_WIDTH    (CW)
    ) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .BTN_A  (BTN_A),
        .BTN_B  (BTN_B),
`ifdef DEBOUNCE_EDGE_EN
        .A_RISE (A_RISE),
        .B_RISE (B_RISE),
`endif
        .A      (A),
        .B      (B)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    logic [3:0] expq[$];

    // Model: raw samples per edge since reset release; the output flips at
    // edge e when the synchronized level (raw from edge e-2) differed from
    // the output on each of the last SC edges, none of them after a flip.
    bit h[2][$];
    bit qm[2];
    int lf[2];
    bit rm[2];

    function automatic logic [3:0] act_now();
`ifdef DEBOUNCE_EDGE_EN
        return {A, B, A_RISE, B_RISE};
`else
        return {A, B, 2'b00};
`endif
    endfunction

    task automatic chk(input string nm, input logic [3:0] act,
                       input logic [3:0] req);
        total++;
        if ((act & MASK) !== (req & MASK)) begin
            bad++;
            $display("FAIL %s t=%0t got=%b want=%b", nm, $time,
                     act & MASK, req & MASK);
        end
    endtask

    function automatic bit s2pre(int ch, int k);
        return (k >= 2) ? h[ch][k-2] : 1'b0;
    endfunction

    task automatic mreset();
        for (int ch = 0; ch < 2; ch++) begin
            h[ch].delete();
            qm[ch] = 1'b0;
            lf[ch] = -1;
            rm[ch] = 1'b0;
        end
    endtask

    task automatic medge(input bit ra, input bit rb);
        bit raw[2];
        raw[0] = ra;
        raw[1] = rb;
        for (int ch = 0; ch < 2; ch++) begin
            int e;
            bit held;
            h[ch].push_back(raw[ch]);
            e = h[ch].size() - 1;
            rm[ch] = 1'b0;
            if (e >= SC - 1 && lf[ch] <= e - SC) begin
                held = 1'b1;
                for (int k = e - SC + 1; k <= e; k++)
                    if (s2pre(ch, k) == qm[ch]) held = 1'b0;
                if (held) begin
                    qm[ch] = ~qm[ch];
                    lf[ch] = e;
                    rm[ch] = qm[ch];
                end
            end
        end
        expq.push_back({qm[0], qm[1], rm[0], rm[1]});
    endtask

    task automatic cyc(input bit a, input bit b);
        BTN_A = a;
        BTN_B = b;
        @(posedge CLK);
        #1;
        medge(a, b);
        #1;
    endtask

    // Assert reset after the monitor's negedge so no stale entry is pending.
    task automatic rst_hold(input int n, input bit a, input bit b);
        #4;
        RST_N = 1'b0;
        BTN_A = a;
        BTN_B = b;
        #1;
        chk("rst_async", act_now(), 4'b0000);
        mreset();
        repeat (n) begin
            @(posedge CLK);
            #1;
            expq.push_back(4'b0000);
            #1;
        end
        RST_N = 1'b1;
    endtask

    always @(negedge CLK) begin
        if (expq.size() > 0) begin
            logic [3:0] e;
            e = expq.pop_front();
            chk("mon", act_now(), e);
        end
    end

    initial begin
        mreset();
        rst_hold(3, 1'b1, 1'b1);
        repeat (5) cyc(1'b1, 1'b1);
        chk("lat_edge4", {A, B, 2'b00}, 4'b0000);
        cyc(1'b1, 1'b1);
        chk("lat_edge5", {A, B, 2'b00}, 4'b1100);
        repeat (8) cyc(1'b0, 1'b0);
        chk("release", {A, B, 2'b00}, 4'b0000);

        repeat (8) cyc(1'b1, 1'b0);
        chk("press_a", {A, B, 2'b00}, 4'b1000);
        repeat (8) cyc(1'b0, 1'b0);

        repeat (3) cyc(1'b1, 1'b0);
        repeat (8) cyc(1'b0, 1'b0);
        chk("glitch", {A, B, 2'b00}, 4'b0000);

        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        repeat (8) cyc(1'b0, 1'b1);
        chk("bounce_b", {A, B, 2'b00}, 4'b0100);
        repeat (8) cyc(1'b0, 1'b0);

        repeat (8) cyc(1'b1, 1'b1);
        repeat (8) cyc(1'b0, 1'b0);

        repeat (8) cyc(1'b1, 1'b1);
        rst_hold(2, 1'b1, 1'b1);
        repeat (8) cyc(1'b0, 1'b0);

        repeat (4) cyc(1'b1, 1'b0);
        rst_hold(2, 1'b1, 1'b0);
        repeat (5) cyc(1'b1, 1'b0);
        chk("midrst_pre", {A, B, 2'b00}, 4'b0000);
        cyc(1'b1, 1'b0);
        chk("midrst_post", {A, B, 2'b00}, 4'b1000);

        for (int i = 0; i < 400; i++) begin
            bit a, b;
            a = 1'($urandom);
            b = 1'($urandom);
            repeat ($urandom_range(1, 7)) cyc(a, b);
            if ($urandom_range(0, 99) == 0)
                rst_hold(int'($urandom_range(1, 3)), a, b);
        end

        repeat (3) @(negedge CLK);
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
